// File: rtl/count_bits_if.sv
// Bus bundle for the count_bits population-count unit: input word and registered count.
`timescale 1ns/1ps
interface count_bits_if #(
    parameter int unsigned DATA_WIDTH = 4
);
    localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;

    logic [DATA_WIDTH-1:0] data;
    logic [CW-1:0]         ones;

    modport master (output data, input ones);
    modport slave  (input data, output ones);
endinterface

// File: rtl/count_bits.sv
// Registered population count: balanced adder tree over the input word, one pipeline stage.
`timescale 1ns/1ps
module count_bits #(
    parameter int unsigned DATA_WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    count_bits_if.slave  bus
);
    localparam int unsigned CW     = $clog2(DATA_WIDTH) + 1;
    localparam int unsigned LEVELS = $clog2(DATA_WIDTH);

    // Node storage is CW bits wide; a node at level l never exceeds 2**l, which fits.
    logic [CW-1:0] w_tree [0:LEVELS][0:DATA_WIDTH-1];
    logic [CW-1:0] r_ones;

    for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_leaf
        assign w_tree[0][j] = CW'(bus.data[j]);
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int unsigned N_IN = (DATA_WIDTH + (1 << l) - 1) >> l;
        for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_node
            if (2 * j + 1 < N_IN) begin : g_add
                assign w_tree[l+1][j] = w_tree[l][2*j] + w_tree[l][2*j+1];
            end else if (2 * j < N_IN) begin : g_pass
                // Odd element carries straight through to the next level
                assign w_tree[l+1][j] = w_tree[l][2*j];
            end else begin : g_zero
                assign w_tree[l+1][j] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ones <= '0;
        end else begin
            r_ones <= w_tree[LEVELS][0];
        end
    end

    assign bus.ones = r_ones;
endmodule

// File: tb/tb_count_bits.sv
// Self-checking bench for count_bits at widths 4, 8, 5 and 1 against a bit-loop reference.
`timescale 1ns/1ps
module tb_count_bits;
    logic clk;
    logic rst_n;
    logic chk_en;
    int   n_checks;
    int   n_fail;

    count_bits_if #(.DATA_WIDTH(4)) if4 ();
    count_bits_if #(.DATA_WIDTH(8)) if8 ();
    count_bits_if #(.DATA_WIDTH(5)) if5 ();
    count_bits_if #(.DATA_WIDTH(1)) if1 ();

    count_bits #(.DATA_WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    count_bits #(.DATA_WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    count_bits #(.DATA_WIDTH(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(if5));
    count_bits #(.DATA_WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pop(input logic [1023:0] v, input int w);
        int c = 0;
        for (int i = 0; i < w; i++) if (v[i] === 1'b1) c++;
        return c;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: count of the word seen at the last live edge, zero while in reset
    int m4, m8, m5, m1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4 = 0; m8 = 0; m5 = 0; m1 = 0;
        end else begin
            m4 = pop(1024'(if4.data), 4);
            m8 = pop(1024'(if8.data), 8);
            m5 = pop(1024'(if5.data), 5);
            m1 = pop(1024'(if1.data), 1);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_w4", int'(if4.ones), rst_n ? m4 : 0);
            check("model_w8", int'(if8.ones), rst_n ? m8 : 0);
            check("model_w5", int'(if5.ones), rst_n ? m5 : 0);
            check("model_w1", int'(if1.ones), rst_n ? m1 : 0);
        end
    end

    // Drive one vector on all widths, then check literal results after the edge (-1 skips)
    task automatic apply(input logic [3:0] d4, input logic [7:0] d8, input logic [4:0] d5,
                         input logic d1, input int e4, input int e8, input int e5, input int e1);
        @(negedge clk);
        if4.data = d4; if8.data = d8; if5.data = d5; if1.data = d1;
        @(posedge clk);
        #1;
        if (e4 >= 0) check("lit_w4", int'(if4.ones), e4);
        if (e8 >= 0) check("lit_w8", int'(if8.ones), e8);
        if (e5 >= 0) check("lit_w5", int'(if5.ones), e5);
        if (e1 >= 0) check("lit_w1", int'(if1.ones), e1);
    endtask

    int sweep_exp [16];

    initial begin
        sweep_exp = '{0,1,1,2,1,2,2,3,1,2,2,3,2,3,3,4};
        n_checks = 0; n_fail = 0; chk_en = 1'b0;
        rst_n = 1'b0;
        if4.data = 4'hF; if8.data = 8'hFF; if5.data = 5'h1F; if1.data = 1'b1;
        #3 chk_en = 1'b1;

        // Reset held with all-ones input
        repeat (3) apply(4'hF, 8'hFF, 5'h1F, 1'b1, 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;

        // Exhaustive 4-bit sweep with fixed patterns elsewhere
        for (int i = 0; i < 16; i++)
            apply(4'(i), 8'hA5, 5'h10, 1'b1, sweep_exp[i], 4, 1, 1);

        apply(4'h1, 8'hFF, 5'h1F, 1'b0, 1, 8, 5, 0);
        apply(4'h2, 8'h80, 5'h10, 1'b1, 1, 1, 1, 1);
        apply(4'h3, 8'h00, 5'h00, 1'b0, 2, 0, 0, 0);

        // Asynchronous reset mid-stream while ones = 3
        apply(4'h7, 8'h07, 5'h07, 1'b1, 3, 3, 3, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_w4", int'(if4.ones), 0);
        check("async_rst_w8", int'(if8.ones), 0);
        check("async_rst_w5", int'(if5.ones), 0);
        check("async_rst_w1", int'(if1.ones), 0);
        @(negedge clk) rst_n = 1'b1;
        apply(4'hF, 8'hFF, 5'h1F, 1'b1, 4, 8, 5, 1);

        // Latency: 0 then F on consecutive edges
        apply(4'h0, 8'h00, 5'h00, 1'b0, 0, 0, 0, 0);
        @(negedge clk);
        if4.data = 4'hF; if8.data = 8'hFF; if5.data = 5'h1F; if1.data = 1'b1;
        #1 check("latency_pre_w4", int'(if4.ones), 0);
        check("latency_pre_w8", int'(if8.ones), 0);
        @(posedge clk);
        #1 check("latency_post_w4", int'(if4.ones), 4);
        check("latency_post_w8", int'(if8.ones), 8);

        // Random back-to-back vectors checked against the reference each cycle
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if4.data = 4'($urandom);
            if8.data = 8'($urandom);
            if5.data = 5'($urandom);
            if1.data = 1'($urandom);
        end
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/count_bits.md
# count_bits

Registered population-count (Hamming weight) unit: counts the number of set bits in a `DATA_WIDTH`-bit input word and presents the count on a registered output one clock later. It is a self-contained datapath leaf block for use wherever a bit-count of a status or mask word is needed, for example arbitration, occupancy or error counting. It has no handshake; it samples its input on every rising clock edge.

## Interface
- `DATA_WIDTH`, default 4: width of the input word. Legal range is 1 to 1024.
- Output width is `CW = $clog2(DATA_WIDTH) + 1`. This is derived and not user-overridable. It is always wide enough to hold the value `DATA_WIDTH`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `data`  in  `DATA_WIDTH`: word to be counted.
- `ones`  out  `CW`: registered count of 1-bits in `data`.

## Operation
- The combinational popcount is built as a balanced binary adder tree over `data`.
  - Leaves are single bits.
  - Each level adds pairs of partial sums, widening each sum by 1 bit.
  - An odd element at any level is zero-extended and passed to the next level.
  - The tree is generated with `generate` loops for any `DATA_WIDTH`.
  - The final sum is truncated or zero-extended to `CW` bits. The maximum value is `DATA_WIDTH`, so it never overflows.
- The result is captured into the output register `ones` on every rising `clk` edge.
- Arithmetic is unsigned only, with no sign handling.
- `DATA_WIDTH = 1` is a degenerate case: `CW = 1` and `ones` is a registered copy of `data[0]`.
- X/Z bits on `data` need no special handling; the result is don't-care.
- There are no other states, modes or enables. The block is a single pipeline stage.

## Timing
- Latency is exactly 1 clock: `ones` after rising edge N equals popcount(`data` sampled at edge N).
- Throughput is one new word per clock. Back-to-back changes of `data` are all counted.
- `data` must meet setup/hold to the `clk` rising edge. Changes between edges only affect the next edge.
- Reset behaviour:
  - While `rst_n` = 0, `ones` = 0, forced immediately and without waiting for `clk`.
  - Asserting reset mid-stream clears `ones` asynchronously.
  - The first rising edge with `rst_n` = 1 captures popcount(`data`) normally.
- Power-up value of `ones` before any reset is don't-care. Benches must apply reset first.
- There is no combinational path from `data` to `ones`.

## Test plan
- **Reset:** hold `rst_n` = 0 with `data` = 4'hF while clocking → `ones` stays 0. Assert `rst_n` low between edges while `ones` = 3 → `ones` goes to 0 before the next edge.
- **Exhaustive sweep (`DATA_WIDTH` = 4, 10 ns clock):** apply `data` = 0..15, one value per cycle, sampling one cycle later.
  - Expected `ones` sequence: 0,1,1,2,1,2,2,3,1,2,2,3,2,3,3,4.
  - `data` = 4'hF must give `ones` = 4, using the full 3-bit range.
- **Latency:** apply `data` = 4'h0 then 4'hF on consecutive edges → `ones` reads 0 after the first edge and 4 after the second, never earlier.
- **Wide instance (`DATA_WIDTH` = 8, `CW` = 4):** 8'hFF → 8, 8'h80 → 1, 8'hA5 → 4, 8'h00 → 0.
- **Odd width (`DATA_WIDTH` = 5, `CW` = 4):** 5'h1F → 5, 5'h10 → 1. Then 200 random vectors checked against a reference bit-loop model with 1-cycle delay.
- **Degenerate width (`DATA_WIDTH` = 1):** `data` = 1 → `ones` = 1 after one edge; `data` = 0 → `ones` = 0.
